// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: access-size codes, error
// causes, controller states and the store-side lane helpers.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] LS_WORD = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_BYTE = 2'd2;
  localparam logic [1:0] LS_LUI  = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_CONFLICT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Byte enables for a little-endian lane; loads and stores use the same mask.
  function automatic logic [3:0] lane_be(input logic [1:0] ls_type, input logic [1:0] lane);
    case (ls_type)
      LS_BYTE: return 4'b0001 << lane;
      LS_HALF: return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store data across every lane so the byte enables alone
  // select which bytes memory writes.
  function automatic logic [31:0] lane_wdata(input logic [1:0] ls_type, input logic [31:0] wdata);
    case (ls_type)
      LS_BYTE: return {4{wdata[7:0]}};
      LS_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Load-side lane extraction: picks the addressed byte/half out of the
// memory word and zero- or sign-extends it to 32 bits.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  ls_type,
  input  logic        ls_unsigned,
  output logic [31:0] ext_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Select the addressed lane and extend according to the access type.
  always_comb begin
    byte_s = rdata[{lane, 3'b000} +: 8];
    half_s = rdata[{lane[1], 4'b0000} +: 16];
    case (ls_type)
      LS_BYTE: ext_data = ls_unsigned ? {24'd0, byte_s} : 32'(byte_s);
      LS_HALF: ext_data = ls_unsigned ? {16'd0, half_s} : 32'(half_s);
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store controller. Holds the core in stall while a
// word-aligned request is outstanding on the handshaked data memory port,
// returns extended load data, and flags misalignment, read/write conflict
// and memory timeout with a one-cycle error pulse.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  ls_type,
  input  logic        ls_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  // Counter value seen in the last REQ cycle before giving up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [1:0]  req_type;
  logic [1:0]  req_lane;
  logic        req_unsigned;
  logic        active;
  logic        conflict;
  logic        misalign;
  logic        timeout;
  logic        launch;
  logic        fail;
  logic [1:0]  fail_cause;
  logic [31:0] aligned;

  assign active   = (mem_read | mem_write) && (ls_type != LS_LUI);
  assign conflict = mem_read & mem_write;
  assign misalign = ((ls_type == LS_WORD) && (addr[1:0] != 2'b00)) ||
                    ((ls_type == LS_HALF) && addr[0]);
  assign timeout  = (cnt == CNT_LAST);

  // Lane extraction uses the type/lane captured at launch, not live inputs.
  lsu_lane_align u_align (
    .rdata       (dmem_rdata),
    .lane        (req_lane),
    .ls_type     (req_type),
    .ls_unsigned (req_unsigned),
    .ext_data    (aligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and control outputs.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    err        = 1'b0;
    ld_valid   = 1'b0;
    launch     = 1'b0;
    fail       = 1'b0;
    fail_cause = CAUSE_NONE;
    case (state)
      ST_IDLE: begin
        // Gated by rst_n so an async reset releases the core immediately.
        stall = active & rst_n;
        if (active) begin
          if (conflict) begin
            state_next = ST_ERR;
            fail       = 1'b1;
            fail_cause = CAUSE_CONFLICT;
          end else if (misalign) begin
            state_next = ST_ERR;
            fail       = 1'b1;
            fail_cause = CAUSE_MISALIGN;
          end else begin
            state_next = ST_REQ;
            launch     = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        // An ack arriving in the timeout cycle still completes the access.
        if (dmem_ack) begin
          state_next = ST_DONE;
        end else if (timeout) begin
          state_next = ST_ERR;
          fail       = 1'b1;
          fail_cause = CAUSE_TIMEOUT;
        end
      end
      ST_DONE: begin
        ld_valid   = ~dmem_we;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        err        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request registers, timeout counter, load result and error cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_be      <= 4'b0000;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      cnt          <= 8'd0;
      req_type     <= LS_WORD;
      req_lane     <= 2'b00;
      req_unsigned <= 1'b0;
      ld_data      <= 32'd0;
      err_cause    <= CAUSE_NONE;
    end else begin
      if (launch) begin
        dmem_req     <= 1'b1;
        dmem_we      <= mem_write;
        dmem_be      <= lane_be(ls_type, addr[1:0]);
        dmem_addr    <= {addr[31:2], 2'b00};
        dmem_wdata   <= lane_wdata(ls_type, wdata);
        cnt          <= 8'd0;
        req_type     <= ls_type;
        req_lane     <= addr[1:0];
        req_unsigned <= ls_unsigned;
      end
      if (state == ST_REQ) begin
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          if (!dmem_we) ld_data <= aligned;
        end else if (timeout) begin
          dmem_req <= 1'b0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      if (fail) err_cause <= fail_cause;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: stimulus pushes expected memory
// requests, load results and error pulses; a monitor pops and compares
// whenever the DUT presents one of them.
module tb_lsu_mem_ctrl;

  localparam int K_REQ = 0;
  localparam int K_LD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  cause;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  ls_type;
  logic        ls_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        err;
  logic [1:0]  err_cause;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int          checks;
  int          failures;
  exp_t        q[$];
  int          ack_delay;
  logic [31:0] rdata_cfg;
  int          stray_tok;
  int          stray_seen;
  int          req_len;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ls_type     (ls_type),
    .ls_unsigned (ls_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .err         (err),
    .err_cause   (err_cause),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = K_REQ; e.we = we; e.be = be; e.addr = a; e.data = d; e.cause = 2'd0;
    q.push_back(e);
  endtask

  task automatic push_ld(input logic [31:0] d);
    exp_t e;
    e.kind = K_LD; e.we = 1'b0; e.be = 4'd0; e.addr = 32'd0; e.data = d; e.cause = 2'd0;
    q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.kind = K_ERR; e.we = 1'b0; e.be = 4'd0; e.addr = 32'd0; e.data = 32'd0; e.cause = c;
    q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input string nm);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s actual=present required=none", nm);
    end else begin
      e = q.pop_front();
      chk({nm, "_kind"}, 32'(kind), 32'(e.kind));
      if (e.kind == kind) begin
        if (kind == K_REQ) begin
          chk("req_we", 32'(dmem_we), 32'(e.we));
          chk("req_be", 32'(dmem_be), 32'(e.be));
          chk("req_addr", dmem_addr, e.addr);
          chk("req_wdata", dmem_wdata, e.data);
        end else if (kind == K_LD) begin
          chk("ld_data", ld_data, e.data);
        end else begin
          chk("err_cause", 32'(err_cause), 32'(e.cause));
          chk("err_stall", 32'(stall), 32'd0);
        end
      end
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin
    logic req_prev;
    int   run;
    req_prev = 1'b0;
    run      = 0;
    req_len  = 0;
    forever begin
      @(negedge clk);
      if (dmem_req && !req_prev) pop_check(K_REQ, "req");
      if (ld_valid) pop_check(K_LD, "ld");
      if (err) pop_check(K_ERR, "err");
      if (dmem_req) run++;
      else if (req_prev) begin
        req_len = run;
        run = 0;
      end
      req_prev = dmem_req;
    end
  end

  // Memory responder: acks ack_delay cycles into a request (0 = never),
  // plus stray acks on demand.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    stray_seen = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (stray_seen != stray_tok) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        stray_seen = stray_tok;
      end else if (dmem_req && ack_delay > 0) begin
        if (wait_cnt == ack_delay - 1) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata_cfg;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Present one access, wait for the stall to drop, check cycle count.
  task automatic access(input string nm, input logic rd, input logic wr, input logic [1:0] t,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int k, input logic [31:0] rword, input int exp_lat);
    int n;
    @(posedge clk);
    #1;
    ack_delay   = k;
    rdata_cfg   = rword;
    mem_read    = rd;
    mem_write   = wr;
    ls_type     = t;
    ls_unsigned = uns;
    addr        = a;
    wdata       = wd;
    n = 1;
    while (n <= 50) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    stray_tok   = 0;
    ack_delay   = 0;
    rdata_cfg   = 32'd0;
    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ls_type     = 2'd0;
    ls_unsigned = 1'b0;
    addr        = 32'd0;
    wdata       = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_ctrl", {28'd0, stall, ld_valid, err, dmem_req}, 32'd0);
    chk("rst_cause_be", {26'd0, err_cause, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lb, sign-extended byte from lane 3
    push_req(1'b0, 4'b1000, 32'h0000_1000, 32'd0);
    push_ld(32'hFFFF_FF80);
    access("lb", 1, 0, 2'd2, 0, 32'h0000_1003, 32'd0, 1, 32'h80FF_0000, 3);

    // lhu / lh on the upper half
    push_req(1'b0, 4'b1100, 32'h0000_1000, 32'd0);
    push_ld(32'h0000_8001);
    access("lhu", 1, 0, 2'd1, 1, 32'h0000_1002, 32'd0, 1, 32'h8001_1234, 3);
    push_req(1'b0, 4'b1100, 32'h0000_1000, 32'd0);
    push_ld(32'hFFFF_8001);
    access("lh", 1, 0, 2'd1, 0, 32'h0000_1002, 32'd0, 1, 32'h8001_1234, 3);

    // sb: replicated data, no load result
    push_req(1'b1, 4'b0010, 32'h0000_2000, 32'hABAB_ABAB);
    access("sb", 0, 1, 2'd2, 0, 32'h0000_2001, 32'h0000_00AB, 2, 32'd0, 4);

    // sh to upper half
    push_req(1'b1, 4'b1100, 32'h0000_6000, 32'hBEEF_BEEF);
    access("sh", 0, 1, 2'd1, 0, 32'h0000_6002, 32'h1234_BEEF, 1, 32'd0, 3);

    // lbu from lane 1, three-cycle memory
    push_req(1'b0, 4'b0010, 32'h0000_5000, 32'd0);
    push_ld(32'h0000_008F);
    access("lbu", 1, 0, 2'd2, 1, 32'h0000_5001, 32'd0, 3, 32'h1234_8F56, 5);

    // misaligned word and half: no request
    push_err(2'd1);
    access("lw_mis", 1, 0, 2'd0, 0, 32'h0000_3002, 32'd0, 1, 32'd0, 2);
    push_err(2'd1);
    access("lh_mis", 1, 0, 2'd1, 0, 32'h0000_1001, 32'd0, 1, 32'd0, 2);

    // timeout: request held 4 cycles
    push_req(1'b0, 4'b1111, 32'h0000_3000, 32'd0);
    push_err(2'd2);
    access("lw_to", 1, 0, 2'd0, 0, 32'h0000_3000, 32'd0, 0, 32'd0, 6);
    chk("to_req_len", 32'(req_len), 32'd4);

    // ack in the timeout cycle completes the load
    push_req(1'b0, 4'b1111, 32'h0000_8000, 32'd0);
    push_ld(32'h0BAD_F00D);
    access("lw_edge", 1, 0, 2'd0, 0, 32'h0000_8000, 32'd0, 4, 32'h0BAD_F00D, 6);

    // read/write conflict, cause held afterwards
    push_err(2'd3);
    access("conflict", 1, 1, 2'd0, 0, 32'h0000_4000, 32'd0, 1, 32'd0, 2);
    repeat (3) @(negedge clk);
    chk("cause_held", 32'(err_cause), 32'd3);

    // lui is not a memory access
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    ls_type  = 2'd3;
    #1;
    chk("lui_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("lui_req", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;

    // reset during an outstanding request
    ack_delay = 0;
    push_req(1'b0, 4'b1111, 32'h0000_9000, 32'd0);
    mem_read = 1'b1;
    ls_type  = 2'd0;
    addr     = 32'h0000_9000;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray_tok++;
    repeat (3) @(negedge clk);
    chk("stray_ack_stall", {30'd0, stall, dmem_req}, 32'd0);
    chk("rst_mid_cause", 32'(err_cause), 32'd0);

    // clean restart
    push_req(1'b0, 4'b1111, 32'h0000_7004, 32'd0);
    push_ld(32'hDEAD_BEEF);
    access("lw_restart", 1, 0, 2'd0, 0, 32'h0000_7004, 32'd0, 2, 32'hDEAD_BEEF, 4);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
